decode_stage: RTL

//  Registered RV32I control-decode pipeline stage between fetch and execute.

---
 rtl/decode_stage.sv | 95 +++++++++
 1 files changed

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I control decode with 2-entry skid buffer and saturating illegal counter
// DECODE_UTYPE_EN: when defined, LUI/AUIPC decode as legal U-type instructions
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      instr_i,
  input  logic [XLEN-1:0]  pc_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  out_pc_o,
  output logic [31:0]      out_instr_o,
  output logic [4:0]       rd_o,
  output logic [4:0]       rs1_o,
  output logic [4:0]       rs2_o,
  output logic             rfwrite_o,
  output logic             alusrc_o,
  output logic             memwrite_o,
  output logic             memread_o,
  output logic             memtoreg_o,
  output logic             branch_o,
  output logic             jal_o,
  output logic             utype_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] illegal_cnt_o
);
  localparam logic [8:0] CTL_ILL = 9'b000000001;
  logic            main_valid_q, skid_valid_q;
  logic [31:0]     skid_instr_q, src_instr;
  logic [XLEN-1:0] skid_pc_q, src_pc;
  logic            accept, main_free, in_ill;
  logic [8:0]      ctl;
  // {rfwrite, alusrc, memwrite, memread, memtoreg, branch, jal, utype, illegal}
  function automatic logic [8:0] decode(input logic [6:0] op);
`ifdef DECODE_UTYPE_EN
    logic is_u = op == 7'b0110111 || op == 7'b0010111;
`else
    logic is_u = 1'b0;
`endif
    return op == 7'b0110011 ? 9'b100000000 :
           op == 7'b0010011 ? 9'b110000000 :
           op == 7'b0000011 ? 9'b110110000 :
           op == 7'b0100011 ? 9'b011000000 :
           op == 7'b1100011 ? 9'b000001000 :
           op == 7'b1101111 ? 9'b100000100 :
           is_u             ? 9'b110000010 : CTL_ILL;
  endfunction
  assign in_ready_o  = ~skid_valid_q & ~flush_i;
  assign accept      = in_valid_i & in_ready_o;
  assign out_valid_o = main_valid_q;
  assign main_free   = ~main_valid_q | out_ready_i;
  assign src_instr   = skid_valid_q ? skid_instr_q : instr_i;
  assign src_pc      = skid_valid_q ? skid_pc_q : pc_i;
  assign ctl         = decode(src_instr[6:0]);
  assign in_ill      = decode(instr_i[6:0]) == CTL_ILL;
  assign rd_o        = out_instr_o[11:7];
  assign rs1_o       = out_instr_o[19:15];
  assign rs2_o       = out_instr_o[24:20];
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_valid_q  <= 1'b0;
      skid_valid_q  <= 1'b0;
      skid_instr_q  <= '0;
      skid_pc_q     <= '0;
      out_pc_o      <= '0;
      out_instr_o   <= '0;
      illegal_cnt_o <= '0;
      {rfwrite_o, alusrc_o, memwrite_o, memread_o, memtoreg_o, branch_o, jal_o, utype_o, illegal_o} <= '0;
    end else begin
      if (accept && in_ill && !(&illegal_cnt_o))
        illegal_cnt_o <= illegal_cnt_o + CNT_W'(1);
      if (flush_i) begin
        main_valid_q <= 1'b0;
        skid_valid_q <= 1'b0;
      end else if (main_free) begin
        main_valid_q <= skid_valid_q | accept;
        skid_valid_q <= 1'b0;
        if (skid_valid_q | accept) begin
          out_pc_o    <= src_pc;
          out_instr_o <= src_instr;
          {rfwrite_o, alusrc_o, memwrite_o, memread_o, memtoreg_o, branch_o, jal_o, utype_o, illegal_o} <= ctl;
        end
      end else if (accept) begin
        skid_valid_q <= 1'b1;
        skid_instr_q <= instr_i;
        skid_pc_q    <= pc_i;
      end
    end
  end
endmodule
